nibble_serial_add_ctrl: RTL and testbench
=========================================

Name: nibble_serial_add_ctrl

Overview:
- Multi-cycle add/subtract sequencer that computes wide operands one 4-bit slice per cycle.
- Holds the inter-slice carry in a register, so one 4-bit ripple-carry adder is reused instead of a full-width chain.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.
- The per-cycle slice add may instantiate the team's existing 4-bit adder module.

Parameters:
- NIBBLES, default 4: number of 4-bit slices. Operand width W = 4*NIBBLES. Legal range 1..16.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand set presented
- in_ready  out  1  controller can accept operands
- a  in  W  operand A, unsigned or two's complement
- b  in  W  operand B
- cin  in  1  carry-in (add) or borrow-in (sub)
- sub  in  1  0: A+B+cin; 1: A-B-cin
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- sum  out  W  result, low W bits
- cout  out  1  carry out of MSB; for sub, 1 = no borrow
- ovf  out  1  signed overflow
- busy  out  1  high in RUN or DONE

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, ovf=0, slice index=0, carry register=0.
- Assertion of rst at any time aborts any operation in flight immediately; no result is emitted.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready at edge k: latch a; latch b, or ~b when sub=1; carry register = cin XOR sub; index=0; go to RUN.
- RUN:
  - in_ready=0; in_valid is ignored and not acknowledged.
  - Each edge: slice i = a[4i+3:4i] + b'[4i+3:4i] + carry.
  - The slice result is written into sum[4i+3:4i]; the slice carry-out goes to the carry register; index increments.
  - On slice NIBBLES-1: cout = carry out of bit W-1; ovf = carry into bit W-1 XOR carry out of bit W-1; go to DONE.
  - The carry into bit W-1 comes from the internal bit-level carry of the top slice.
- Latency: the result is registered at edge k+NIBBLES; out_valid is high from edge k+NIBBLES onward.
- DONE:
  - out_valid=1.
  - sum, cout and ovf are stable while out_valid & !out_ready.
  - On out_ready: out_valid=0, go to IDLE at that edge.
  - in_ready rises at that same edge. No overlap between a result handshake and an operand handshake in the same cycle.
- Width rules:
  - All arithmetic is modulo 2^W; cout carries the 2^W bit.
  - For sub, cout=1 iff A >= B+cin, treating operands as unsigned.
- Output hold:
  - sum is only meaningful while out_valid=1. It may change during RUN.
  - cout and ovf change only at the final slice edge.
  - After the DONE handshake, outputs retain the last result until the next operation overwrites them.
- Throughput: one operation per NIBBLES+2 cycles minimum (accept, NIBBLES slices, handshake).
- The carry register is never cleared between slices except by reset or a new acceptance.
- Boundary cases:
  - NIBBLES=1: one RUN cycle.
  - index wraps to 0 on the transition to DONE.
  - in_valid held continuously: the next operand is accepted only in IDLE.

Test Plan:
- NIBBLES=4, a=0xFFFF, b=0x0001, cin=0, sub=0, out_ready=1 -> out_valid exactly 4 cycles after the accept edge; sum=0x0000, cout=1, ovf=0.
- a=0x7FFF, b=0x0001, cin=0, sub=0 -> sum=0x8000, cout=0, ovf=1. Then a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
- sub=1, a=0x0005, b=0x0007, cin=0 -> sum=0xFFFE, cout=0, ovf=0. Then sub=1, a=0x0010, b=0x0001, cin=1 -> sum=0x000E, cout=1.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> sum, cout and ovf are unchanged and in_ready=0 throughout. out_ready=1 -> IDLE next edge. A second operand held on in_valid since RUN is accepted only after that edge.
- Reset mid-op: assert rst asynchronously 2 cycles into RUN -> all outputs 0 and in_ready=1 immediately, with no out_valid pulse. A following 0x1234+0x1111 yields 0x2345.
- NIBBLES=1: a=0xF, b=0x1, cin=1 -> out_valid 1 cycle after accept; sum=0x1, cout=1, ovf=0.

Source files
------------

// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: serial add/subtract sequencer, one 4-bit slice per cycle with a registered inter-slice carry
module nibble_serial_add_ctrl #(
   parameter int NIBBLES = 4,
   localparam int W = 4 * NIBBLES
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   input  logic         sub,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] sum,
   output logic         cout,
   output logic         ovf,
   output logic         busy
);
   localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t        state, state_nx;
   logic [W-1:0]  ra, rb;
   logic          carry;
   logic [IW-1:0] idx;
   logic [4:0]    s5;
   logic [3:0]    lo;
   logic [W+3:0]  sh;
   logic          last;
   assign last      = idx == IW'(NIBBLES - 1);
   assign s5        = {1'b0, ra[3:0]} + {1'b0, rb[3:0]} + {4'd0, carry};
   assign lo        = {1'b0, ra[2:0]} + {1'b0, rb[2:0]} + {3'd0, carry};
   assign sh        = {s5[3:0], sum} >> 4;
   assign in_ready  = state == IDLE;
   assign out_valid = state == DONE;
   assign busy      = state != IDLE;
   // state register
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else     state <= state_nx;
   // next-state: accept, walk the slices, wait for the consumer
   always_comb begin
      state_nx = state;
      if (state == IDLE && in_valid) state_nx = RUN;
      else if (state == RUN && last) state_nx = DONE;
      else if (state == DONE && out_ready) state_nx = IDLE;
   end
   // datapath: operands shift down one slice per cycle, results shift in from the top
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         ra    <= '0;
         rb    <= '0;
         carry <= 1'b0;
         idx   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
      end else if (state == IDLE && in_valid) begin
         ra    <= a;
         rb    <= sub ? ~b : b;
         carry <= cin ^ sub;
         idx   <= '0;
      end else if (state == RUN) begin
         ra    <= ra >> 4;
         rb    <= rb >> 4;
         carry <= s5[4];
         sum   <= sh[W-1:0];
         idx   <= last ? '0 : idx + IW'(1);
         if (last) begin
            cout <= s5[4];
            ovf  <= lo[3] ^ s5[4];
         end
      end
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb_nibble_serial_add_ctrl: directed bench for the 4-slice and 1-slice configurations
module tb_nibble_serial_add_ctrl;
   logic        clk = 0, rst = 1;
   logic        in_valid = 0, out_ready = 0, cin = 0, sub = 0;
   logic [15:0] a = 0, b = 0;
   logic        in_ready, out_valid, cout, ovf, busy;
   logic [15:0] sum;
   logic        v1 = 0, r1 = 0, c1 = 0, s1 = 0;
   logic [3:0]  a1 = 0, b1 = 0;
   logic        ir1, ov1, co1, of1, bz1;
   logic [3:0]  sm1;
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   nibble_serial_add_ctrl #(.NIBBLES(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf), .busy(busy));

   nibble_serial_add_ctrl #(.NIBBLES(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(v1), .in_ready(ir1), .a(a1), .b(b1),
      .cin(c1), .sub(s1), .out_valid(ov1), .out_ready(r1),
      .sum(sm1), .cout(co1), .ovf(of1), .busy(bz1));

   task automatic test_reset;
      #3;
      checks++;
      if ({in_ready, out_valid, busy, sum, cout, ovf} !== {3'b100, 16'h0, 2'b00}) begin
         errors++;
         $display("FAIL reset4 got rdy=%b vld=%b busy=%b sum=%h c=%b o=%b want 1 0 0 0000 0 0",
                  in_ready, out_valid, busy, sum, cout, ovf);
      end
      checks++;
      if ({ir1, ov1, bz1, sm1, co1, of1} !== {3'b100, 4'h0, 2'b00}) begin
         errors++;
         $display("FAIL reset1 got rdy=%b vld=%b busy=%b sum=%h c=%b o=%b want 1 0 0 0 0 0",
                  ir1, ov1, bz1, sm1, co1, of1);
      end
      @(negedge clk) rst = 0;
   endtask

   task automatic run_op(input string nm, input logic [15:0] ta, input logic [15:0] tb2,
                         input logic tc, input logic ts, input logic [15:0] es,
                         input logic ec, input logic eo);
      @(negedge clk);
      a = ta; b = tb2; cin = tc; sub = ts; in_valid = 1; out_ready = 1;
      @(posedge clk);
      @(negedge clk) in_valid = 0;
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL %s_run got rdy=%b busy=%b want 0 1", nm, in_ready, busy);
      end
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== (i == 4)) begin
            errors++;
            $display("FAIL %s_lat cycle %0d got vld=%b want %b", nm, i, out_valid, i == 4);
         end
      end
      checks++;
      if (sum !== es || cout !== ec || ovf !== eo) begin
         errors++;
         $display("FAIL %s_res got sum=%h c=%b o=%b want %h %b %b", nm, sum, cout, ovf, es, ec, eo);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s_idle got vld=%b rdy=%b want 0 1", nm, out_valid, in_ready);
      end
   endtask

   task automatic test_add;
      run_op("ffff_p1", 16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0);
      run_op("7fff_p1", 16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1);
      run_op("8000_p8000", 16'h8000, 16'h8000, 0, 0, 16'h0000, 1, 1);
   endtask

   task automatic test_sub;
      run_op("5_m7", 16'h0005, 16'h0007, 0, 1, 16'hFFFE, 0, 0);
      run_op("10_m1_m1", 16'h0010, 16'h0001, 1, 1, 16'h000E, 1, 0);
   endtask

   task automatic test_back_to_back;
      @(negedge clk);
      a = 16'h1234; b = 16'h0101; cin = 0; sub = 0; in_valid = 1; out_ready = 0;
      @(posedge clk);
      @(negedge clk) begin a = 16'h00FF; b = 16'h0F01; end
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== (i == 4) || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_run cycle %0d got vld=%b rdy=%b want %b 0", i, out_valid, in_ready, i == 4);
         end
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (sum !== 16'h1335 || cout !== 0 || ovf !== 0 || in_ready !== 0 || out_valid !== 1) begin
            errors++;
            $display("FAIL bp_hold %0d got sum=%h c=%b o=%b rdy=%b vld=%b want 1335 0 0 0 1",
                     i, sum, cout, ovf, in_ready, out_valid);
         end
      end
      out_ready = 1;
      @(negedge clk);
      checks++;
      if (out_valid !== 0 || in_ready !== 1 || busy !== 0) begin
         errors++;
         $display("FAIL bp_release got vld=%b rdy=%b busy=%b want 0 1 0", out_valid, in_ready, busy);
      end
      @(negedge clk) in_valid = 0;
      checks++;
      if (in_ready !== 0 || busy !== 1) begin
         errors++;
         $display("FAIL bp_accept2 got rdy=%b busy=%b want 0 1", in_ready, busy);
      end
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== (i == 4)) begin
            errors++;
            $display("FAIL bp_lat2 cycle %0d got vld=%b want %b", i, out_valid, i == 4);
         end
      end
      checks++;
      if (sum !== 16'h1000 || cout !== 0 || ovf !== 0) begin
         errors++;
         $display("FAIL bp_res2 got sum=%h c=%b o=%b want 1000 0 0", sum, cout, ovf);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_op;
      @(negedge clk);
      a = 16'h1234; b = 16'h1111; cin = 0; sub = 0; in_valid = 1; out_ready = 1;
      @(posedge clk);
      @(negedge clk) in_valid = 0;
      @(negedge clk);
      @(negedge clk);
      #1 rst = 1;
      #1;
      checks++;
      if ({in_ready, out_valid, busy, sum, cout, ovf} !== {3'b100, 16'h0, 2'b00}) begin
         errors++;
         $display("FAIL rst_mid got rdy=%b vld=%b busy=%b sum=%h c=%b o=%b want 1 0 0 0000 0 0",
                  in_ready, out_valid, busy, sum, cout, ovf);
      end
      @(negedge clk) rst = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 0 || in_ready !== 1) begin
            errors++;
            $display("FAIL rst_nopulse %0d got vld=%b rdy=%b want 0 1", i, out_valid, in_ready);
         end
      end
      run_op("post_rst", 16'h1234, 16'h1111, 0, 0, 16'h2345, 0, 0);
   endtask

   task automatic test_nibbles1;
      @(negedge clk);
      a1 = 4'hF; b1 = 4'h1; c1 = 1; s1 = 0; v1 = 1; r1 = 1;
      @(posedge clk);
      @(negedge clk) v1 = 0;
      checks++;
      if (ov1 !== 0 || bz1 !== 1) begin
         errors++;
         $display("FAIL n1_run got vld=%b busy=%b want 0 1", ov1, bz1);
      end
      @(negedge clk);
      checks++;
      if (ov1 !== 1 || sm1 !== 4'h1 || co1 !== 1 || of1 !== 0) begin
         errors++;
         $display("FAIL n1_res got vld=%b sum=%h c=%b o=%b want 1 1 1 0", ov1, sm1, co1, of1);
      end
      @(negedge clk);
      checks++;
      if (ov1 !== 0 || ir1 !== 1) begin
         errors++;
         $display("FAIL n1_idle got vld=%b rdy=%b want 0 1", ov1, ir1);
      end
   endtask

   initial begin
      test_reset;
      test_add;
      test_sub;
      test_back_to_back;
      test_reset_mid_op;
      test_nibbles1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
